// File: rtl/arm_alu_seq.sv
// arm_alu_seq: registered ARM data-processing ALU with an iterative shift-add MUL/MLA engine,
// an internal NZCV flag register and a START/BUSY/DONE handshake.
module arm_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic             s_i,
  input  logic             flags_we_i,
  input  logic [3:0]       flags_in_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_out_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_e;

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             s_mul_q, s_mul_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] add_x_s, add_y_s, logic_res_s, alu_res_s, mul_sum_s;
  logic [WIDTH:0]   sum_s;
  logic             add_cin_s, is_arith_s, is_logic_s, is_cmp_s, is_mul_s, ovf_s;
  logic [3:0]       alu_flags_s, flags_hold_s;

  // Opcode decode and single-cycle datapath; subtracts are folded into A+~B+cin form
  always_comb begin
    add_x_s     = a_i;
    add_y_s     = b_i;
    add_cin_s   = 1'b0;
    is_arith_s  = 1'b0;
    is_logic_s  = 1'b0;
    is_cmp_s    = 1'b0;
    is_mul_s    = 1'b0;
    logic_res_s = {WIDTH{1'b0}};
    case (op_i)
      5'b00000: begin is_logic_s = 1'b1; logic_res_s = a_i & b_i; end
      5'b00001: begin is_logic_s = 1'b1; logic_res_s = a_i ^ b_i; end
      5'b00010: begin is_arith_s = 1'b1; add_y_s = ~b_i; add_cin_s = 1'b1; end
      5'b00011: begin is_arith_s = 1'b1; add_x_s = b_i; add_y_s = ~a_i; add_cin_s = 1'b1; end
      5'b00100: begin is_arith_s = 1'b1; end
      5'b00101: begin is_arith_s = 1'b1; add_cin_s = flags_q[1]; end
      5'b00110: begin is_arith_s = 1'b1; add_y_s = ~b_i; add_cin_s = flags_q[1]; end
      5'b00111: begin is_arith_s = 1'b1; add_x_s = b_i; add_y_s = ~a_i; add_cin_s = flags_q[1]; end
      5'b01000: begin is_logic_s = 1'b1; is_cmp_s = 1'b1; logic_res_s = a_i & b_i; end
      5'b01001: begin is_logic_s = 1'b1; is_cmp_s = 1'b1; logic_res_s = a_i ^ b_i; end
      5'b01010: begin is_arith_s = 1'b1; is_cmp_s = 1'b1; add_y_s = ~b_i; add_cin_s = 1'b1; end
      5'b01011: begin is_arith_s = 1'b1; is_cmp_s = 1'b1; end
      5'b01100: begin is_logic_s = 1'b1; logic_res_s = a_i | b_i; end
      5'b01101: begin is_logic_s = 1'b1; logic_res_s = b_i; end
      5'b01110: begin is_logic_s = 1'b1; logic_res_s = a_i & ~b_i; end
      5'b01111: begin is_logic_s = 1'b1; logic_res_s = ~b_i; end
      5'b10000: begin is_logic_s = 1'b1; logic_res_s = b_i; end
      5'b10001: begin is_logic_s = 1'b1; logic_res_s = a_i + {{(WIDTH-1){1'b0}}, 1'b1}; end
      5'b10010, 5'b10011: begin is_mul_s = 1'b1; end
      default: begin logic_res_s = {WIDTH{1'b0}}; end
    endcase
    sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{WIDTH{1'b0}}, add_cin_s};
    ovf_s = (add_x_s[WIDTH-1] == add_y_s[WIDTH-1]) && (sum_s[WIDTH-1] != add_x_s[WIDTH-1]);
    if (is_arith_s) begin
      alu_res_s   = sum_s[WIDTH-1:0];
      alu_flags_s = {sum_s[WIDTH-1], ~|sum_s[WIDTH-1:0], sum_s[WIDTH], ovf_s};
    end else begin
      alu_res_s   = logic_res_s;
      alu_flags_s = {logic_res_s[WIDTH-1], ~|logic_res_s, flags_q[1:0]};
    end
  end

  // Handshake FSM, multiply iterations and flag-register write arbitration
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    done_d    = 1'b0;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    s_mul_d   = s_mul_q;
    if (flags_we_i) begin
      flags_hold_s = flags_in_i;
    end else begin
      flags_hold_s = flags_q;
    end
    flags_d   = flags_hold_s;
    mul_sum_s = prod_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
    case (state_q)
      ST_IDLE: begin
        if (start_i && is_mul_s) begin
          state_d  = ST_MUL;
          mcand_d  = a_i;
          mplier_d = b_i;
          prod_d   = op_i[0] ? acc_i : {WIDTH{1'b0}};
          cnt_d    = {CW{1'b0}};
          s_mul_d  = s_i;
        end else if (start_i) begin
          done_d = 1'b1;
          if ((is_arith_s || is_logic_s) && !is_cmp_s) begin
            result_d = alu_res_s;
          end else begin
            result_d = result_q;
          end
          // ALU flag writes take priority over a same-edge direct load
          if (is_cmp_s || ((is_arith_s || is_logic_s) && s_i)) begin
            flags_d = alu_flags_s;
          end else begin
            flags_d = flags_hold_s;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      ST_MUL: begin
        prod_d   = mul_sum_s;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          result_d = mul_sum_s;
          if (s_mul_q) begin
            flags_d = {mul_sum_s[WIDTH-1], ~|mul_sum_s, flags_q[1:0]};
          end else begin
            flags_d = flags_hold_s;
          end
        end else begin
          state_d = ST_MUL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= {WIDTH{1'b0}};
      flags_q  <= 4'b0000;
      done_q   <= 1'b0;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      prod_q   <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      s_mul_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      s_mul_q  <= s_mul_d;
    end
  end

  assign result_o    = result_q;
  assign flags_out_o = flags_q;
  assign busy_o      = (state_q == ST_MUL);
  assign done_o      = done_q;

endmodule

// File: tb/tb_arm_alu_seq.sv
// Randomised self-checking bench for arm_alu_seq: a 32-bit instance checked against an
// arithmetic reference model, plus an 8-bit instance for the narrow-width multiply case.
module tb_arm_alu_seq;
  localparam int W  = 32;
  localparam int W8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, s, fwe;
  logic [4:0]    op;
  logic [W-1:0]  a, b, acc, res;
  logic [3:0]    fin, flg;
  logic          busy, done;

  logic          start8, s8, fwe8;
  logic [4:0]    op8;
  logic [W8-1:0] a8, b8, acc8, res8;
  logic [3:0]    fin8, flg8;
  logic          busy8, done8;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] m_res;
  logic [3:0]   m_flags;

  arm_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b), .acc_i(acc),
    .s_i(s), .flags_we_i(fwe), .flags_in_i(fin), .result_o(res), .flags_out_o(flg),
    .busy_o(busy), .done_o(done)
  );

  arm_alu_seq #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8), .acc_i(acc8),
    .s_i(s8), .flags_we_i(fwe8), .flags_in_i(fin8), .result_o(res8), .flags_out_o(flg8),
    .busy_o(busy8), .done_o(done8)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    int unsigned k;
    k = $urandom_range(0, 5);
    case (k)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Reference: ARM semantics using wide integer arithmetic and signed range checks.
  task automatic model_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input logic sf, input logic fw, input logic [3:0] fi);
    int          kind;
    logic [31:0] p, q, r;
    longint      e, t;
    logic        c, v, wr, setf, known, cin;
    logic [3:0]  nf;
    kind = 0; p = x; q = y; e = 0; t = 0; r = 32'h0;
    c = 1'b0; wr = 1'b1; setf = sf; known = 1'b1; cin = m_flags[1];
    case (o)
      5'd0:  r = x & y;
      5'd1:  r = x ^ y;
      5'd2:  kind = 2;
      5'd3:  begin kind = 2; p = y; q = x; end
      5'd4:  kind = 1;
      5'd5:  begin kind = 1; e = cin ? 64'sd1 : 64'sd0; end
      5'd6:  begin kind = 2; e = cin ? 64'sd0 : 64'sd1; end
      5'd7:  begin kind = 2; p = y; q = x; e = cin ? 64'sd0 : 64'sd1; end
      5'd8:  begin r = x & y; wr = 1'b0; setf = 1'b1; end
      5'd9:  begin r = x ^ y; wr = 1'b0; setf = 1'b1; end
      5'd10: begin kind = 2; wr = 1'b0; setf = 1'b1; end
      5'd11: begin kind = 1; wr = 1'b0; setf = 1'b1; end
      5'd12: r = x | y;
      5'd13: r = y;
      5'd14: r = x & ~y;
      5'd15: r = ~y;
      5'd16: r = y;
      5'd17: r = x + 32'd1;
      5'd18: r = 32'(64'(x) * 64'(y));
      5'd19: r = 32'(64'(x) * 64'(y) + 64'(z));
      default: known = 1'b0;
    endcase
    if (kind == 1) begin
      r = 32'(longint'(p) + longint'(q) + e);
      c = (longint'(p) + longint'(q) + e) > 64'sd4294967295;
      t = longint'($signed(p)) + longint'($signed(q)) + e;
    end else if (kind == 2) begin
      r = 32'(longint'(p) - longint'(q) - e);
      c = longint'(p) >= (longint'(q) + e);
      t = longint'($signed(p)) - longint'($signed(q)) - e;
    end
    v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    if (kind != 0) nf = {r[31], r == 32'h0, c, v};
    else           nf = {r[31], r == 32'h0, m_flags[1:0]};
    if (fw) m_flags = fi;
    if (known) begin
      if (wr)   m_res = r;
      if (setf) m_flags = nf;
    end
  endtask

  // Single-cycle op: called at a negedge, returns at the negedge of cycle 1 with START still high.
  task automatic sop(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic sf, input logic fw, input logic [3:0] fi, input string tag);
    start = 1'b1; op = o; a = x; b = y; acc = $urandom; s = sf; fwe = fw; fin = fi;
    model_op(o, x, y, acc, sf, fw, fi);
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_res"}, res, m_res);
    check_val({tag, "_flags"}, flg, m_flags);
  endtask

  task automatic idle_cycle(input string tag);
    start = 1'b0; fwe = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_done_low"}, done, 0);
  endtask

  task automatic fload(input logic [3:0] fi);
    start = 1'b0; fwe = 1'b1; fin = fi; m_flags = fi;
    @(posedge clk);
    @(negedge clk);
    fwe = 1'b0;
    check_val("fload_flags", flg, m_flags);
  endtask

  task automatic mop(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                     input logic sf, input int poke, input logic rnd_we, input string tag);
    start = 1'b1; op = o; a = x; b = y; acc = z; s = sf; fwe = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= W; k++) begin
      check_val({tag, "_busy"}, busy, 1);
      check_val({tag, "_no_done"}, done, 0);
      check_val({tag, "_busy_flags"}, flg, m_flags);
      start = (k == poke); op = 5'd4; a = $urandom; b = $urandom; acc = $urandom; s = 1'b1;
      fwe = rnd_we && ($urandom_range(0, 3) == 0); fin = 4'($urandom);
      @(posedge clk);
      if (k < W) begin
        if (fwe) m_flags = fin;
      end else begin
        model_op(o, x, y, z, sf, fwe, fin);
      end
      @(negedge clk);
    end
    start = 1'b0; fwe = 1'b0;
    check_val({tag, "_busy_end"}, busy, 0);
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_res"}, res, m_res);
    check_val({tag, "_flags"}, flg, m_flags);
  endtask

  initial begin
    logic [4:0] ro;
    bit         saw_done;
    int         cyc;
    rst_n = 1'b0; start = 1'b0; op = 5'd0; a = '0; b = '0; acc = '0; s = 1'b0; fwe = 1'b0; fin = 4'd0;
    start8 = 1'b0; op8 = 5'd0; a8 = '0; b8 = '0; acc8 = '0; s8 = 1'b0; fwe8 = 1'b0; fin8 = 4'd0;
    repeat (2) @(negedge clk);
    check_val("rst_res", res, 0);
    check_val("rst_flags", flg, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    rst_n = 1'b1; m_res = '0; m_flags = 4'b0000;
    @(negedge clk);

    sop(5'd4, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 4'd0, "add_ovf");
    check_val("add_ovf_res_k", res, 32'h8000_0000);
    check_val("add_ovf_nzcv_k", flg, 4'b1001);
    idle_cycle("add_ovf");
    sop(5'd2, 32'd5, 32'd5, 1'b1, 1'b0, 4'd0, "sub");
    check_val("sub_nzcv_k", flg, 4'b0110);
    sop(5'd10, 32'd3, 32'd5, 1'b0, 1'b0, 4'd0, "cmp");
    check_val("cmp_res_k", res, 32'h0);
    check_val("cmp_nzcv_k", flg, 4'b1000);
    fload(4'b0010);
    sop(5'd5, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 4'd0, "adc");
    check_val("adc_res_k", res, 32'h0);
    check_val("adc_nzcv_k", flg, 4'b0110);
    fload(4'b0000);
    sop(5'd6, 32'd5, 32'd3, 1'b1, 1'b0, 4'd0, "sbc");
    check_val("sbc_res_k", res, 32'h1);

    fload(4'b0011);
    mop(5'd18, 32'h1_0000, 32'h1_0000, 32'h0, 1'b1, 5, 1'b0, "mul");
    check_val("mul_res_k", res, 32'h0);
    check_val("mul_nzcv_k", flg, 4'b0111);
    idle_cycle("mul_poke");
    mop(5'd19, 32'd7, 32'd6, 32'd100, 1'b0, 0, 1'b0, "mla");
    check_val("mla_res_k", res, 32'h8E);
    check_val("mla_flags_k", flg, 4'b0111);
    sop(5'd4, 32'd1, 32'd1, 1'b1, 1'b1, 4'b1111, "prec");
    check_val("prec_flags_k", flg, 4'b0000);
    idle_cycle("prec");

    for (int i = 0; i < 150; i++) begin
      ro = 5'($urandom_range(0, 31));
      if (ro == 5'd18 || ro == 5'd19) ro = 5'd17;
      sop(ro, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 4'($urandom), "rnd");
      if ($urandom_range(0, 7) == 0) idle_cycle("rnd");
    end
    for (int j = 0; j < 6; j++) begin
      mop(5'($urandom_range(18, 19)), rnd_val(), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)),
          $urandom_range(1, W - 1), 1'b1, "rmul");
      sop(5'd4, rnd_val(), rnd_val(), 1'b1, 1'b0, 4'd0, "after_mul");
      idle_cycle("after_mul");
    end

    start = 1'b1; op = 5'd18; a = $urandom; b = $urandom; s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_res", res, 0);
    check_val("abort_flags", flg, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < W + 8; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_val("abort_no_done", saw_done, 0);

    start8 = 1'b1; op8 = 5'd18; a8 = 8'h0F; b8 = 8'h11; s8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    check_val("w8_busy_c1", busy8, 1);
    cyc = 1;
    while (!done8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_val("w8_done_cycle", cyc, 9);
    check_val("w8_res", res8, 8'hFF);
    check_val("w8_nzcv", flg8, 4'b1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
